// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types and width defaults for the MIPS memory stage.
//            Holds the memory-access FSM state encoding and the MEM/WB
//            pipeline bundle carried from the memory stage into write-back.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_REG_W  = 5;

    // Memory-access FSM: IDLE issues, WAIT holds the request until ready.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    // MEM/WB pipeline register contents.
    typedef struct packed {
        logic                   mem_to_reg;
        logic                   reg_write;
        logic [MIPS_DATA_W-1:0] read_data;
        logic [MIPS_DATA_W-1:0] alu_result;
        logic [MIPS_REG_W-1:0]  write_reg;
    } mem_wb_t;

    // A bubble carries no architectural effect; data fields are zeroed so
    // that waveforms stay readable.
    function automatic mem_wb_t mem_wb_bubble();
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_reg
// Purpose  : MEM/WB pipeline register with bubble insertion.
// Ports    : clk, reset  - clock, asynchronous active-high clear
//            load        - capture wb_i on the next rising edge
//            bubble      - capture an empty entry (takes priority over load)
//            wb_i        - next MEM/WB contents
//            wb_o        - registered MEM/WB contents
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t wb_i,
    output mem_wb_t wb_o
);

    mem_wb_t wb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q <= '0;
        end else if (bubble) begin
            wb_q <= mem_wb_bubble();
        end else if (load) begin
            wb_q <= wb_i;
        end
    end

    assign wb_o = wb_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage. Performs the data-memory access over a
//            ready handshake, resolves the branch, holds MEM/WB and counts
//            stalled cycles.
// Ports    : clk, reset            - clock, asynchronous active-high reset
//            *_in                  - EX/MEM register outputs
//            dmem_*                - data memory request/response
//            stall                 - hold EX/MEM and earlier stages
//            pc_src, branch_target - branch resolution
//            *_out                 - MEM/WB register outputs
//            stall_count           - saturating stalled-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_W  = MIPS_REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_in,
    input  logic              mem_read_in,
    input  logic              mem_to_reg_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic [DATA_W-1:0] add_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [REG_W-1:0]  mux_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  write_reg_out,
    output logic [CNT_W-1:0]  stall_count
);

    mem_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              mem_op;
    logic              stall_d;
    logic              issue;
    logic              complete;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;

    assign mem_op   = mem_read_in | mem_write_in;
    assign issue    = (state_q == S_IDLE) & mem_op;
    assign complete = (state_q == S_WAIT) & dmem_ready;

    // Next state, stall and MEM/WB input
    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d = S_IDLE;
                end else begin
                    stall_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wb_d            = '0;
        wb_d.mem_to_reg = mem_to_reg_in;
        wb_d.reg_write  = reg_write_in;
        wb_d.alu_result = alu_result_in;
        wb_d.write_reg  = mux_in;
        // Only a completing load returns memory data; a store or a
        // non-memory instruction writes zero into the read-data field.
        wb_d.read_data  = (complete && !we_q) ? dmem_rdata : '0;
    end

    // FSM with request latches. The write flag doubles as the registered
    // dmem_we output, so it is cleared when the access completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                addr_q  <= alu_result_in;
                wdata_q <= read_data2_in;
                // A simultaneous read and write is treated as a write.
                we_q    <= mem_write_in;
            end else if (complete) begin
                we_q    <= 1'b0;
            end
        end
    end

    // Saturating stalled-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stall_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (~stall_d),
        .bubble (stall_d),
        .wb_i   (wb_d),
        .wb_o   (wb_q)
    );

    // Request decodes the state register only, so it cannot glitch.
    assign dmem_req       = (state_q == S_WAIT);
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;

    assign stall          = stall_d;
    // A branch is never taken while EX/MEM is frozen by a stall.
    assign pc_src         = branch_in & zero_in & ~stall_d;
    assign branch_target  = add_in;

    assign mem_to_reg_out = wb_q.mem_to_reg;
    assign reg_write_out  = wb_q.reg_write;
    assign read_data_out  = wb_q.read_data;
    assign alu_result_out = wb_q.alu_result;
    assign write_reg_out  = wb_q.write_reg;
    assign stall_count    = cnt_q;

endmodule
`default_nettype wire
